// File: rtl/nbit_pow_seq.sv
// nbit_pow_seq: sequential ain**bin by right-to-left square-and-multiply, one exponent bit per clock; `POW_SATURATE_EN clamps out on overflow
module nbit_pow_seq #(
  parameter int WIDTH     = 6,
  parameter int EXP_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     ain,
  input  logic [EXP_WIDTH-1:0] bin,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     out,
  output logic                 overflow
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t               state, state_n;
  logic [WIDTH-1:0]     res, res_n, base, base_n, out_n;
  logic [EXP_WIDTH-1:0] exp, exp_n;
  logic                 base_ovf, base_ovf_n, acc_ovf, acc_ovf_n, ovf_n;
  logic [2*WIDTH-1:0]   p, q;
  assign p    = {{WIDTH{1'b0}}, res} * {{WIDTH{1'b0}}, base};
  assign q    = {{WIDTH{1'b0}}, base} * {{WIDTH{1'b0}}, base};
  assign busy = state == RUN;
  assign done = state == DONE;
  // next state: one exponent bit per RUN cycle; result latched into out when the last set bit is consumed
  always_comb begin
    state_n    = state;
    res_n      = res;
    base_n     = base;
    exp_n      = exp;
    base_ovf_n = base_ovf;
    acc_ovf_n  = acc_ovf;
    out_n      = out;
    ovf_n      = overflow;
    if (state == RUN) begin
      res_n      = exp[0] ? p[WIDTH-1:0] : res;
      acc_ovf_n  = acc_ovf | (exp[0] & (base_ovf | (|p[2*WIDTH-1:WIDTH])));
      base_n     = q[WIDTH-1:0];
      base_ovf_n = base_ovf | (|q[2*WIDTH-1:WIDTH]);
      exp_n      = exp >> 1;
      if (exp_n == '0) begin
        state_n = DONE;
`ifdef POW_SATURATE_EN
        out_n   = acc_ovf_n ? {WIDTH{1'b1}} : res_n;
`else
        out_n   = res_n;
`endif
        ovf_n   = acc_ovf_n;
      end
    end else if (start) begin
      state_n    = RUN;
      res_n      = {{(WIDTH-1){1'b0}}, 1'b1};
      base_n     = ain;
      exp_n      = bin;
      base_ovf_n = 1'b0;
      acc_ovf_n  = 1'b0;
    end else begin
      state_n = IDLE;
    end
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      res      <= {{(WIDTH-1){1'b0}}, 1'b1};
      base     <= '0;
      exp      <= '0;
      base_ovf <= 1'b0;
      acc_ovf  <= 1'b0;
      out      <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      res      <= res_n;
      base     <= base_n;
      exp      <= exp_n;
      base_ovf <= base_ovf_n;
      acc_ovf  <= acc_ovf_n;
      out      <= out_n;
      overflow <= ovf_n;
    end
  end
endmodule

// File: tb/tb_nbit_pow_seq.sv
// tb_nbit_pow_seq: vector table, hand corner sequences and random ops against an arithmetic power model
module tb_nbit_pow_seq;
  localparam int W = 6;
  localparam int M = 1 << W;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] ain = '0, bin = '0;
  logic         busy, done, overflow;
  logic [W-1:0] out;
  int           errors = 0, checks = 0;

  nbit_pow_seq #(.WIDTH(W), .EXP_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ain(ain), .bin(bin),
    .busy(busy), .done(done), .out(out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int val;
    int ovf;
    int lat;
  } vec_t;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic int sat(input int val, input int ovf);
`ifdef POW_SATURATE_EN
    return ovf != 0 ? M - 1 : val;
`else
    return ovf != 0 ? val : val;
`endif
  endfunction

  function automatic void model(input int a, input int b, output int o, output int ov, output int l);
    int t;
    t = 1;
    o = 1;
    for (int i = 0; i < b; i++) begin
      o = (o * a) % M;
      t = t * a;
      if (t > M) t = M;
    end
    ov = (t >= M) ? 1 : 0;
    l = 1;
    for (int i = 0; i < W; i++) if (((b >> i) & 1) != 0) l = i + 1;
  endfunction

  task automatic launch(input int a, input int b);
    @(negedge clk);
    start = 1'b1;
    ain = W'(a);
    bin = W'(b);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 64) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_check(input string name, input int a, input int b, input int val, input int ovf, input int lat);
    int n;
    launch(a, b);
    chk({name, " busy"}, int'(busy), 1);
    wait_done(1, n);
    chk({name, " latency"}, n, lat + 1);
    chk({name, " out"}, int'(out), sat(val, ovf));
    chk({name, " overflow"}, int'(overflow), ovf);
    @(negedge clk);
    chk({name, " done pulse"}, int'(done), 0);
    chk({name, " out held"}, int'(out), sat(val, ovf));
  endtask

  vec_t vecs[$];

  initial begin
    int n, o, ov, l, a, b;
    vecs = '{
      '{3, 3, 27, 0, 2}, '{2, 6, 0, 1, 3}, '{0, 0, 1, 0, 1}, '{1, 63, 1, 0, 6},
      '{7, 2, 49, 0, 2}, '{8, 2, 0, 1, 2}, '{0, 5, 0, 0, 3}, '{63, 1, 63, 0, 1},
      '{2, 5, 32, 0, 3}, '{2, 32, 0, 1, 6}, '{4, 3, 0, 1, 2}, '{3, 4, 17, 1, 3},
      '{9, 1, 9, 0, 1}, '{8, 1, 8, 0, 1}, '{5, 0, 1, 0, 1}, '{63, 63, 63, 1, 6}
    };
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset out", int'(out), 0);
    chk("reset overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].val, vecs[i].ovf, vecs[i].lat);
    launch(3, 5);
    start = 1'b1;
    ain = 6'd2;
    bin = 6'd6;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, n);
    chk("ignore latency", n, 4);
    chk("ignore out", int'(out), sat(51, 1));
    chk("ignore overflow", int'(overflow), 1);
    start = 1'b1;
    ain = 6'd7;
    bin = 6'd2;
    @(negedge clk);
    start = 1'b0;
    chk("donestart busy", int'(busy), 1);
    wait_done(1, n);
    chk("donestart latency", n, 3);
    chk("donestart out", int'(out), 49);
    chk("donestart overflow", int'(overflow), 0);
    launch(5, 7);
    @(negedge clk);
    chk("pre-reset busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("async busy", int'(busy), 0);
    chk("async done", int'(done), 0);
    chk("async out", int'(out), 0);
    chk("async overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_check("post-reset", 3, 3, 27, 0, 2);
    for (int k = 0; k < 40; k++) begin
      a = int'($urandom_range(0, M - 1));
      b = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, M - 1)) : int'($urandom_range(0, 4));
      model(a, b, o, ov, l);
      run_check($sformatf("rand%0d a=%0d b=%0d", k, a, b), a, b, o, ov, l);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
